// File: rtl/sample_ring_buffer_if.sv
// Sample/trigger/readout bundle between the capture front end and sample_ring_buffer.
// The bench or front end drives it through master; the buffer uses slave.
interface sample_ring_buffer_if #(
    parameter int WIDTH = 1,
    parameter int AW    = 15
);
    logic             wea;
    logic [WIDTH-1:0] dina;
    logic             arm;
    logic             trig;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] douta;
    logic             rd_valid;
    logic             rd_oor;
    logic             busy;
    logic             done;
    logic [AW:0]      count;
    logic [AW:0]      trig_pos;

    modport master (
        output wea, dina, arm, trig, rd_en, rd_addr,
        input  douta, rd_valid, rd_oor, busy, done, count, trig_pos
    );

    modport slave (
        input  wea, dina, arm, trig, rd_en, rd_addr,
        output douta, rd_valid, rd_oor, busy, done, count, trig_pos
    );
endinterface

// File: rtl/sample_ring_buffer.sv
// Circular capture buffer: records a sample stream, freezes POST samples after trigger, reads by logical index.
// Optional macro RINGBUF_OUTREG_EN adds an output register stage (2-cycle read latency).
module sample_ring_buffer #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 30000,
    parameter int AW    = 15,
    parameter int POST  = 15000
) (
    input logic                 clka,
    input logic                 rsta,
    sample_ring_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StPost,
        StDone
    } state_t;

    localparam logic [AW:0]   DepthW  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PostW   = (AW+1)'(POST);
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW:0]      postCnt_q, postCnt_d;
    logic [AW:0]      trigPos_q;
    logic             busy_q, done_q;
    logic             wrAccept, lastPost;

    logic [AW:0]      rdSum;
    logic [AW-1:0]    rdPhys;
    logic             rdOor, rdHit;
    logic [WIDTH-1:0] douta1_q;
    logic             valid1_q, oor1_q;

    // Write acceptance and pointer/counter next values; arm discards a same-cycle sample.
    always_comb begin
        wrAccept  = !rsta && !bus.arm && bus.wea && (state_q == StPre || state_q == StPost);
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        postCnt_d = postCnt_q;
        if (wrAccept) begin
            wrPtr_d = (wrPtr_q == LastIdx) ? '0 : wrPtr_q + 1'b1;
            if (count_q != DepthW) begin
                count_d = count_q + 1'b1;
            end
            if (state_q == StPost) begin
                postCnt_d = postCnt_q + 1'b1;
            end
        end
        lastPost = (state_q == StPost) && wrAccept && (postCnt_d == PostW);
    end

    // Once the ring has filled, the oldest sample sits at the write pointer.
    always_comb begin
        rdSum = {1'b0, wrPtr_q} + {1'b0, bus.rd_addr};
        if (count_q != DepthW) begin
            rdPhys = bus.rd_addr;
        end else if (rdSum >= DepthW) begin
            rdPhys = AW'(rdSum - DepthW);
        end else begin
            rdPhys = rdSum[AW-1:0];
        end
        rdOor = ({1'b0, bus.rd_addr} >= count_q);
        rdHit = bus.rd_en && (state_q == StDone);
    end

    always_ff @(posedge clka) begin
        if (wrAccept) begin
            mem[wrPtr_q] <= bus.dina;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q   <= StIdle;
            wrPtr_q   <= '0;
            count_q   <= '0;
            postCnt_q <= '0;
            trigPos_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.arm) begin
            state_q   <= StPre;
            wrPtr_q   <= '0;
            count_q   <= '0;
            postCnt_q <= '0;
            trigPos_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            postCnt_q <= postCnt_d;
            case (state_q)
                StPre: begin
                    if (bus.trig) begin
                        if (POST == 0) begin
                            state_q   <= StDone;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            trigPos_q <= count_d - PostW;
                        end else begin
                            state_q <= StPost;
                        end
                    end
                end
                StPost: begin
                    if (lastPost) begin
                        state_q   <= StDone;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        trigPos_q <= count_d - PostW;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            valid1_q <= 1'b0;
            oor1_q   <= 1'b0;
            douta1_q <= '0;
        end else begin
            valid1_q <= rdHit;
            if (rdHit) begin
                oor1_q   <= rdOor;
                douta1_q <= rdOor ? '0 : mem[rdPhys];
            end
        end
    end

`ifdef RINGBUF_OUTREG_EN
    logic [WIDTH-1:0] douta2_q;
    logic             valid2_q, oor2_q;

    always_ff @(posedge clka) begin
        if (rsta) begin
            valid2_q <= 1'b0;
            oor2_q   <= 1'b0;
            douta2_q <= '0;
        end else begin
            valid2_q <= valid1_q;
            if (valid1_q) begin
                oor2_q   <= oor1_q;
                douta2_q <= douta1_q;
            end
        end
    end

    assign bus.douta    = douta2_q;
    assign bus.rd_valid = valid2_q;
    assign bus.rd_oor   = oor2_q;
`else
    assign bus.douta    = douta1_q;
    assign bus.rd_valid = valid1_q;
    assign bus.rd_oor   = oor1_q;
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.trig_pos = trigPos_q;

endmodule
